// File: rtl/ls_arbiter.sv
// ls_arbiter: arbitrates the single-port 32KB local store SRAM
// (2048 x 128-bit quadwords) between DMA bursts, the SPU load/store pipe
// and instruction fetch.
//
// Priority: DMA > load/store > fetch. A fetch that has waited IF_STARVE_MAX
// cycles preempts everything when the port is idle. A DMA grant locks the
// port for DMA_BURST consecutive beats.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   dma_*             DMA burst request/grant, write data, done pulse
//   ls_*              load/store request/grant, write data
//   if_*              fetch request/grant
//   rdata, *_rvalid   registered read return, tagged by owner, 2 cycles
//                     after the read grant
//   mem_*             SRAM port (1-cycle read latency, write-first)
module ls_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int QW_IDX_W      = 11,
    parameter int DMA_BURST     = 8,
    parameter int IF_STARVE_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [0:ADDR_W-1]   dma_addr,
    input  logic [0:127]        dma_wdata,
    output logic                dma_gnt,
    output logic                dma_done,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [0:ADDR_W-1]   ls_addr,
    input  logic [0:127]        ls_wdata,
    output logic                ls_gnt,

    input  logic                if_req,
    input  logic [0:ADDR_W-1]   if_addr,
    output logic                if_gnt,

    output logic [0:127]        rdata,
    output logic                dma_rvalid,
    output logic                ls_rvalid,
    output logic                if_rvalid,

    output logic                mem_en,
    output logic                mem_we,
    output logic [0:QW_IDX_W-1] mem_addr,
    output logic [0:127]        mem_wdata,
    input  logic [0:127]        mem_rdata
);

    localparam int CNT_W = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DMA_BURST - 1);
    localparam logic [3:0]       STARVE_MAX = 4'(IF_STARVE_MAX);

    typedef enum logic {IDLE, BURST} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [0:QW_IDX_W-1]  base_q, base_d;
    logic                 bwe_q, bwe_d;
    logic [3:0]           starve_q, starve_d;
    // read tag pipe, one-hot {dma, ls, if}
    logic [2:0]           tag_q, tag_d;
    logic [2:0]           rv_q, rv_d;
    logic [0:127]         rdata_q, rdata_d;

    logic                 dma_g, ls_g, if_g, done;

    // byte address -> quadword index (low 4 bits are ignored)
    logic [0:QW_IDX_W-1]  dma_idx, ls_idx, if_idx;
    assign dma_idx = dma_addr[0:QW_IDX_W-1];
    assign ls_idx  = ls_addr[0:QW_IDX_W-1];
    assign if_idx  = if_addr[0:QW_IDX_W-1];

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{dma_addr[QW_IDX_W:ADDR_W-1],
                               ls_addr[QW_IDX_W:ADDR_W-1],
                               if_addr[QW_IDX_W:ADDR_W-1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        bwe_d   = bwe_q;
        dma_g   = 1'b0;
        ls_g    = 1'b0;
        if_g    = 1'b0;
        done    = 1'b0;

        // grants are held off while reset is asserted so the SRAM port
        // is quiet immediately, not just after the next edge
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (if_req && starve_q == STARVE_MAX) begin
                        if_g = 1'b1;
                    end else if (dma_req) begin
                        dma_g  = 1'b1;
                        base_d = dma_idx;
                        bwe_d  = dma_we;
                        if (DMA_BURST == 1) begin
                            done = 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = BURST;
                        end
                    end else if (ls_req) begin
                        ls_g = 1'b1;
                    end else if (if_req) begin
                        if_g = 1'b1;
                    end
                end
                BURST: begin
                    // port is locked; dma_req is not looked at again
                    dma_g = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // SRAM port mux
    always_comb begin
        mem_en    = dma_g | ls_g | if_g;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_g) begin
            mem_we    = (state_q == BURST) ? bwe_q : dma_we;
            // index arithmetic is modulo 2048, so bursts wrap 2047 -> 0
            mem_addr  = (state_q == BURST) ? base_q + QW_IDX_W'(cnt_q) : dma_idx;
            mem_wdata = dma_wdata;
        end else if (ls_g) begin
            mem_we    = ls_we;
            mem_addr  = ls_idx;
            mem_wdata = ls_wdata;
        end else if (if_g) begin
            mem_addr  = if_idx;
        end
    end

    // starvation counter and read-return pipe
    always_comb begin
        if (if_req && !if_g) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
        end else begin
            starve_d = '0;
        end

        tag_d = (mem_en && !mem_we) ? {dma_g, ls_g, if_g} : 3'b000;
        rv_d  = tag_q;
        // capture SRAM output only when a read is coming back
        rdata_d = (|tag_q) ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            bwe_q    <= 1'b0;
            starve_q <= '0;
            tag_q    <= '0;
            rv_q     <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            bwe_q    <= bwe_d;
            starve_q <= starve_d;
            tag_q    <= tag_d;
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dma_gnt    = dma_g;
    assign ls_gnt     = ls_g;
    assign if_gnt     = if_g;
    assign dma_done   = done;
    assign dma_rvalid = rv_q[2];
    assign ls_rvalid  = rv_q[1];
    assign if_rvalid  = rv_q[0];
    assign rdata      = rdata_q;

endmodule

// File: doc/ls_arbiter.md
Name: ls_arbiter

Overview:
Arbitrates the single-port 32KB local store SRAM (2048 quadwords of 128 bits) between three requesters: DMA (MFC) bursts, the SPU load/store pipe (lqx/stqx and related quadword accesses), and instruction fetch. Fixed priority is DMA > load/store > fetch. A starvation counter guarantees fetch progress. A burst FSM locks the port for the length of a DMA transfer.

Parameters:
ADDR_W, 15, byte address width (32KB local store)
QW_IDX_W, 11, quadword index width, equal to ADDR_W-4
DMA_BURST, 8, quadwords per DMA transfer (128-byte line)
IF_STARVE_MAX, 15, waiting cycles after which fetch preempts load/store

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
dma_req  in  1  DMA transfer request, held until dma_done
dma_we  in  1  1 = store burst, 0 = load burst; sampled at burst start
dma_addr  in  [0:14]  burst start byte address; bits [11:14] ignored
dma_wdata  in  [0:127]  store beat data, consumed when dma_gnt=1
dma_gnt  out  1  beat accepted this cycle
dma_done  out  1  one-cycle pulse on the last beat grant
ls_req  in  1  load/store request, held until ls_gnt
ls_we  in  1  1 = store quadword
ls_addr  in  [0:14]  byte address; bits [11:14] ignored (quadword aligned)
ls_wdata  in  [0:127]  store data
ls_gnt  out  1  request accepted this cycle
if_req  in  1  fetch request, held until if_gnt
if_addr  in  [0:14]  fetch byte address; bits [11:14] ignored
if_gnt  out  1  request accepted this cycle
rdata  out  [0:127]  read return data, shared by all requesters
dma_rvalid, ls_rvalid, if_rvalid  out  1 each  rdata belongs to this requester
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  [0:10]  SRAM quadword index
mem_wdata  out  [0:127]  SRAM write data
mem_rdata  in  [0:127]  SRAM read data, valid 1 cycle after a read access

Behaviour:
- FSM states: IDLE and BURST.
- IDLE grant selection, combinational and evaluated each cycle:
  - if_req and starve_cnt==IF_STARVE_MAX: grant fetch.
  - else dma_req: grant DMA beat 0, latch beat counter=1, base index = dma_addr[0:10], dma_we. Go to BURST, unless DMA_BURST==1, which pulses dma_done and stays in IDLE.
  - else ls_req: grant load/store.
  - else if_req: grant fetch.
- BURST: dma_gnt=1 every cycle, with mem_addr = (base+count) mod 2048; index wraps 2047 -> 0. Count increments each beat. On beat DMA_BURST-1, pulse dma_done and return to IDLE. No other requester is granted in BURST, even at the starvation limit. dma_req is not rechecked mid-burst.
- Exactly one gnt per cycle at most. mem_en = OR of the grants. mem_we, mem_addr and mem_wdata are muxed from the granted requester.
- starve_cnt (4 bits): increments when if_req=1 and if_gnt=0, saturating at IF_STARVE_MAX. Clears on if_gnt or when if_req=0.
- Read return: on a granted read, a 2-deep tag pipe records the owner. The owner's rvalid asserts 2 cycles after the grant: SRAM latency 1 plus a register stage. rdata is registered from mem_rdata. Writes produce no rvalid.
- Read-after-write to the same index on consecutive cycles returns the new data; SRAM write-first is required.
- Reset (reset=0, asynchronous) at any time, including mid-burst:
  - state=IDLE, counters=0, starve_cnt=0.
  - all gnt, rvalid, dma_done=0; rdata=0.
  - mem_en=0, mem_we=0.
  - The burst is aborted and the requester must re-request.
- Grants are combinational from registered state and current requests. Requesters drop req the cycle after gnt, or keep it high to issue a new access.

Test Plan:
- Reset, then ls_req=1, ls_we=1, ls_addr=0x0013, ls_wdata=0xA5..A5 -> ls_gnt same cycle, mem_addr=1, mem_we=1. Then an ls read at 0x0010 -> ls_rvalid 2 cycles later with rdata=0xA5..A5.
- dma_req with dma_addr=0x7FC0, dma_we=0, and ls_req held -> 8 consecutive dma_gnt with mem_addr 2044,2045,2046,2047,0,1,2,3. dma_done on the 8th. ls_gnt only after the burst. dma_rvalid for 8 cycles, offset by 2.
- dma_req, ls_req and if_req all asserted in the same cycle from IDLE -> dma_gnt first. After the burst, ls_gnt. if_gnt after ls_req drops.
- if_req held while ls_req held continuously -> if_gnt on exactly the 16th cycle of waiting, i.e. when starve_cnt=15. ls_gnt in every other cycle. starve_cnt=0 after the grant.
- Assert reset=0 asynchronously on beat 3 of a DMA store burst -> all outputs 0 immediately. After release, dma_req restarts from beat 0 with 8 fresh grants.
- Same-index back-to-back: ls store then fetch read of the same index on the next cycle -> if_rvalid returns the stored data.
